// File: rtl/dom_pkg.sv
// Shared constants, refresh-width helper and sequencer state type for the DOM AND slice.
package dom_pkg;

  localparam int SHARES = 4;

  // One fresh bit per unordered share pair.
  function automatic int calc_rand_bits(input int shares);
    return (shares * (shares - 1)) / 2;
  endfunction

  localparam int RAND_BITS = calc_rand_bits(SHARES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/dom_rand_buf.sv
// One-entry buffer for PRNG refresh words; a consumed word is scrubbed to zero so it
// can never be presented to the gadget a second time.
module dom_rand_buf #(
  parameter int W = dom_pkg::RAND_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rnd_valid_i,
  output logic         rnd_ready_o,
  input  logic [W-1:0] rnd_data_i,
  input  logic         consume_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  assign rnd_ready_o = !full_q;
  assign full_o      = full_q;
  assign data_o      = data_q;

  // Consume only happens while full, and loads only while empty, so they never collide.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (consume_i) begin
      full_d = 1'b0;
      data_d = '0;
    end else if (rnd_valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = rnd_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/dom_and_sequencer.sv
// Drives one DOM AND gadget: one operation in flight, gadget inputs pulsed for a single
// cycle with a fresh refresh word and held at zero otherwise.
module dom_and_sequencer #(
  parameter int SHARES     = dom_pkg::SHARES,
  parameter int RAND_BITS  = dom_pkg::calc_rand_bits(SHARES),
  parameter int GADGET_LAT = 1,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SHARES-1:0]    in_a,
  input  logic [SHARES-1:0]    in_b,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  input  logic [RAND_BITS-1:0] rnd_data,
  output logic [SHARES-1:0]    g_a,
  output logic [SHARES-1:0]    g_b,
  output logic [RAND_BITS-1:0] g_r,
  input  logic [SHARES-1:0]    g_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SHARES-1:0]    out_c,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  import dom_pkg::*;

  localparam int WCNT_W = (GADGET_LAT > 1) ? $clog2(GADGET_LAT) : 1;

  seq_state_e           state_q, state_d;
  logic [SHARES-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
  logic [SHARES-1:0]    ga_q, ga_d, gb_q, gb_d;
  logic [RAND_BITS-1:0] gr_q, gr_d;
  logic                 live_q, live_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic [SHARES-1:0]    out_c_q, out_c_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_W-1:0]     op_count_q, op_count_d;

  logic                 rbuf_full;
  logic [RAND_BITS-1:0] rbuf_data;
  logic                 consume;

  assign consume = (state_q == ISSUE) && rbuf_full;

  dom_rand_buf #(
    .W (RAND_BITS)
  ) u_rand_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .rnd_valid_i (rnd_valid),
    .rnd_ready_o (rnd_ready),
    .rnd_data_i  (rnd_data),
    .consume_i   (consume),
    .full_o      (rbuf_full),
    .data_o      (rbuf_data)
  );

  // live_q marks the cycle the registered gadget lines carry the operation; the
  // latency countdown starts only once they have returned to zero.
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    ga_d        = '0;
    gb_d        = '0;
    gr_d        = '0;
    live_d      = 1'b0;
    wcnt_d      = wcnt_q;
    out_c_d     = out_c_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rbuf_full) begin
          ga_d    = op_a_q;
          gb_d    = op_b_q;
          gr_d    = rbuf_data;
          op_a_d  = '0;
          op_b_d  = '0;
          wcnt_d  = WCNT_W'(GADGET_LAT - 1);
          live_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!live_q) begin
          if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - WCNT_W'(1);
          end else begin
            out_c_d     = g_c;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      ga_q        <= '0;
      gb_q        <= '0;
      gr_q        <= '0;
      live_q      <= 1'b0;
      wcnt_q      <= '0;
      out_c_q     <= '0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      ga_q        <= ga_d;
      gb_q        <= gb_d;
      gr_q        <= gr_d;
      live_q      <= live_d;
      wcnt_q      <= wcnt_d;
      out_c_q     <= out_c_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign g_a       = ga_q;
  assign g_b       = gb_q;
  assign g_r       = gr_q;
  assign out_c     = out_c_q;
  assign out_valid = out_valid_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_dom_and_sequencer.sv
// Directed bench for dom_and_sequencer with a 1-cycle behavioural 4-share DOM AND gadget.
module tb_dom_and_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_a = '0;
  logic [3:0]  in_b = '0;
  logic        rnd_valid = 1'b0;
  logic        rnd_ready;
  logic [5:0]  rnd_data = '0;
  logic [3:0]  g_a, g_b;
  logic [5:0]  g_r;
  logic [3:0]  g_c = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_c;
  logic        busy;
  logic [15:0] op_count;

  int total = 0;
  int bad = 0;
  int expCount = 0;
  logic [5:0] issueLog[$];

  always #5 clk = ~clk;

  dom_and_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_data  (rnd_data),
    .g_a       (g_a),
    .g_b       (g_b),
    .g_r       (g_r),
    .g_c       (g_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .busy      (busy),
    .op_count  (op_count)
  );

  // Refresh bit k belongs to share pair (i,j), i<j, enumerated row by row.
  function automatic logic [3:0] domAnd(input logic [3:0] a, input logic [3:0] b, input logic [5:0] r);
    logic [3:0] c;
    int k;
    c = a & b;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        c[i] = c[i] ^ (a[i] & b[j]) ^ r[k];
        c[j] = c[j] ^ (a[j] & b[i]) ^ r[k];
        k++;
      end
    end
    return c;
  endfunction

  always @(posedge clk) g_c <= domAnd(g_a, g_b, g_r);

  always @(negedge clk) begin
    if (g_a != '0 || g_b != '0 || g_r != '0) issueLog.push_back(g_r);
  end

  task automatic push_rnd(input logic [5:0] w);
    int n;
    n = 0;
    rnd_valid = 1'b1;
    rnd_data  = w;
    while (!rnd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rnd_ready) begin
      total++; bad++;
      $display("[TB] FAIL push_rnd timeout: rnd_ready=%0b required=1", rnd_ready);
    end
    @(negedge clk);
    rnd_valid = 1'b0;
    rnd_data  = '0;
  endtask

  task automatic push_op(input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("[TB] FAIL push_op timeout: in_ready=%0b required=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) begin
      total++; bad++;
      $display("[TB] FAIL wait_out timeout: out_valid=%0b required=1", out_valid);
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    expCount++;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_c, op_count, g_a, g_b, g_r, busy} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: ov=%0b c=%h cnt=%h ga=%h gb=%h gr=%h busy=%0b required all 0",
               out_valid, out_c, op_count, g_a, g_b, g_r, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || rnd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_ready: in_ready=%0b rnd_ready=%0b required 1 1", in_ready, rnd_ready);
    end
  endtask

  task automatic test_basic();
    int cyc;
    issueLog.delete();
    push_rnd(6'b101101);
    total++;
    if (rnd_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_rnd_buffered: rnd_ready=%0b required 0", rnd_ready);
    end
    push_op(4'b0001, 4'b0111);
    wait_out(cyc);
    total++;
    if (cyc != 3) begin
      bad++;
      $display("[TB] FAIL basic_latency: got %0d cycles required 3", cyc);
    end
    total++;
    if (issueLog.size() != 1 || issueLog[0] !== 6'b101101) begin
      bad++;
      $display("[TB] FAIL basic_g_r: pulses=%0d first=%h required 1 pulse of 2d", issueLog.size(),
               issueLog.size() > 0 ? issueLog[0] : 6'h0);
    end
    total++;
    if (out_c !== domAnd(4'b0001, 4'b0111, 6'b101101) || ^out_c !== 1'b1) begin
      bad++;
      $display("[TB] FAIL basic_out_c: got %b required %b (xor 1)", out_c, domAnd(4'b0001, 4'b0111, 6'b101101));
    end
    take_out();
    total++;
    if (op_count !== 16'(expCount) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL basic_count: cnt=%0d ov=%0b in_ready=%0b required cnt=%0d ov=0 in_ready=1",
               op_count, out_valid, in_ready, expCount);
    end
  endtask

  task automatic test_starvation();
    int cyc;
    issueLog.delete();
    push_op(4'b1011, 4'b1101);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || {g_a, g_b, g_r} !== '0) begin
        bad++;
        $display("[TB] FAIL starve_hold[%0d]: busy=%0b in_ready=%0b ga=%h gb=%h gr=%h required 1 0 0 0 0",
                 i, busy, in_ready, g_a, g_b, g_r);
      end
      @(negedge clk);
    end
    rnd_valid = 1'b1;
    rnd_data  = 6'h2C;
    @(negedge clk);
    rnd_valid = 1'b0;
    rnd_data  = '0;
    total++;
    if ({g_a, g_b, g_r} !== '0) begin
      bad++;
      $display("[TB] FAIL starve_load_cycle: ga=%h gb=%h gr=%h required 0", g_a, g_b, g_r);
    end
    @(negedge clk);
    total++;
    if (g_a !== 4'b1011 || g_b !== 4'b1101 || g_r !== 6'h2C) begin
      bad++;
      $display("[TB] FAIL starve_issue: ga=%b gb=%b gr=%h required 1011 1101 2c", g_a, g_b, g_r);
    end
    wait_out(cyc);
    total++;
    if (out_c !== domAnd(4'b1011, 4'b1101, 6'h2C) || ^out_c !== 1'b1 || issueLog.size() != 1) begin
      bad++;
      $display("[TB] FAIL starve_result: c=%b pulses=%0d required %b 1", out_c, issueLog.size(),
               domAnd(4'b1011, 4'b1101, 6'h2C));
    end
    take_out();
  endtask

  task automatic test_no_reuse();
    logic [5:0] words [3];
    logic [3:0] as [3];
    logic [3:0] bs [3];
    logic       prod [3];
    int cyc;
    words[0] = 6'h15; words[1] = 6'h2A; words[2] = 6'h3F;
    as[0] = 4'b0011;  as[1] = 4'b1110;  as[2] = 4'b1000;
    bs[0] = 4'b0101;  bs[1] = 4'b0001;  bs[2] = 4'b1111;
    prod[0] = 1'b0;   prod[1] = 1'b1;   prod[2] = 1'b0;
    issueLog.delete();
    for (int k = 0; k < 3; k++) begin
      push_rnd(words[k]);
      total++;
      if (rnd_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reuse_ready[%0d]: rnd_ready=%0b required 0", k, rnd_ready);
      end
      push_op(as[k], bs[k]);
      wait_out(cyc);
      total++;
      if (^out_c !== prod[k]) begin
        bad++;
        $display("[TB] FAIL reuse_prod[%0d]: xor=%0b required %0b", k, ^out_c, prod[k]);
      end
      take_out();
    end
    total++;
    if (issueLog.size() != 3) begin
      bad++;
      $display("[TB] FAIL reuse_pulses: got %0d required 3", issueLog.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (issueLog[k] !== words[k]) begin
          bad++;
          $display("[TB] FAIL reuse_order[%0d]: g_r=%h required %h", k, issueLog[k], words[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [3:0] expC;
    expC = domAnd(4'b0100, 4'b0010, 6'h07);
    push_rnd(6'h07);
    push_op(4'b0100, 4'b0010);
    wait_out(cyc);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_c !== expC || in_ready !== 1'b0 || op_count !== 16'(expCount)) begin
        bad++;
        $display("[TB] FAIL bp_hold[%0d]: ov=%0b c=%b in_ready=%0b cnt=%0d required 1 %b 0 %0d",
                 i, out_valid, out_c, in_ready, op_count, expC, expCount);
      end
      @(negedge clk);
    end
    take_out();
    total++;
    if (op_count !== 16'(expCount) || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_count: cnt=%0d ov=%0b required %0d 0", op_count, out_valid, expCount);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    push_rnd(6'h11);
    push_op(4'b0101, 4'b0011);
    @(negedge clk);
    rnd_valid = 1'b1;
    rnd_data  = 6'h22;
    @(negedge clk);
    rnd_valid = 1'b0;
    rnd_data  = '0;
    total++;
    if (busy !== 1'b1 || rnd_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_pre: busy=%0b rnd_ready=%0b required 1 0", busy, rnd_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_c, op_count, g_a, g_b, g_r, busy} !== '0 || rnd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrst_async: ov=%0b c=%h cnt=%h ga=%h gb=%h gr=%h busy=%0b rr=%0b required 0s rr=1",
               out_valid, out_c, op_count, g_a, g_b, g_r, busy, rnd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    expCount = 0;
    issueLog.delete();
    total++;
    if (rnd_ready !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrst_release: rnd_ready=%0b in_ready=%0b required 1 1", rnd_ready, in_ready);
    end
    push_rnd(6'h33);
    push_op(4'b1001, 4'b0110);
    wait_out(cyc);
    total++;
    if (issueLog.size() != 1 || issueLog[0] !== 6'h33 || ^out_c !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_next: pulses=%0d g_r=%h xor=%0b required 1 33 0", issueLog.size(),
               issueLog.size() > 0 ? issueLog[0] : 6'h0, ^out_c);
    end
    take_out();
  endtask

  task automatic test_counter_wrap();
    int cyc;
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    expCount = 16'hFFFF;
    total++;
    if (op_count !== 16'hFFFF) begin
      bad++;
      $display("[TB] FAIL wrap_preset: cnt=%h required ffff", op_count);
    end
    push_rnd(6'h0B);
    push_op(4'b0010, 4'b0100);
    wait_out(cyc);
    take_out();
    total++;
    if (op_count !== 16'(expCount)) begin
      bad++;
      $display("[TB] FAIL wrap_count: cnt=%h required %h", op_count, 16'(expCount));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_starvation();
    test_no_reuse();
    test_backpressure();
    test_reset_mid_op();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dom_and_sequencer.md
Name: dom_and_sequencer

Overview:
- Sequences one 4-share DOM AND gadget (SHARES shares, SHARES*(SHARES-1)/2 refresh bits, one register stage).
- Accepts masked operand pairs over valid/ready and buffers fresh randomness from a PRNG stream.
- Issues each operation with a never-reused refresh word, waits out the gadget latency, and returns the masked product over valid/ready.
- Sits between the masked datapath scheduler and the gadget instance. It owns all gadget input lines.

Parameters:
- SHARES, 4: number of shares per operand.
- RAND_BITS, 6: refresh bits per operation; must equal SHARES*(SHARES-1)/2.
- GADGET_LAT, 1: gadget register stages, ≥1.
- CNT_W, 16: width of the operation counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid&in_ready
- in_a  in  SHARES  shares of operand a
- in_b  in  SHARES  shares of operand b
- rnd_valid  in  1  PRNG word valid
- rnd_ready  out  1  PRNG word accepted when rnd_valid&rnd_ready
- rnd_data  in  RAND_BITS  fresh randomness
- g_a  out  SHARES  gadget operand a
- g_b  out  SHARES  gadget operand b
- g_r  out  RAND_BITS  gadget refresh bits
- g_c  in  SHARES  gadget output shares
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&out_ready
- out_c  out  SHARES  result shares (registered)
- busy  out  1  state != IDLE
- op_count  out  CNT_W  completed operations, wraps

Behaviour:
- Reset is asynchronous on rst_n low. It forces:
  - state=IDLE
  - out_valid=0, out_c=0, op_count=0
  - rbuf_full=0, with rbuf, op_a and op_b cleared
  - g_a/g_b/g_r=0
  - in_ready=1 after release
- A reset mid-operation discards the operation and any buffered randomness. Nothing is replayed.
- Randomness buffer: one entry. rnd_ready = !rbuf_full. A word is loaded on handshake.
- A word is consumed (rbuf_full<=0, rbuf<=0) at the end of the ISSUE cycle that uses it. It is never used twice. No refill occurs in the same cycle it is consumed.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On the in handshake, latch op_a/op_b and move to ISSUE.
- ISSUE:
  - If rbuf_full: drive g_a=op_a, g_b=op_b, g_r=rbuf for exactly this cycle, clear op_a/op_b/rbuf, load wcnt=GADGET_LAT-1, and move to WAIT.
  - Otherwise stall in ISSUE with the gadget lines held at 0.
- WAIT:
  - Gadget lines are 0.
  - While wcnt!=0, decrement wcnt.
  - When wcnt==0, register out_c<=g_c, set out_valid=1 and move to DONE.
- DONE:
  - out_valid=1, with out_c stable until the handshake.
  - On out_ready, out_valid<=0, op_count<=op_count+1 (mod 2^CNT_W), and move to IDLE.
- g_a/g_b/g_r are registered, and equal 0 in every cycle other than the single issue cycle. This zero-precharge is mandatory.
- in_ready=0 in ISSUE/WAIT/DONE. There is one operation in flight.
- Latency with randomness available: in handshake at edge E0 → out_valid high after edge E0+2+GADGET_LAT. That is 3 cycles for the default.
- The PRNG may prefill rbuf during IDLE, WAIT or DONE. This hides randomness latency for the next operation.
- Simultaneous rnd handshake and ISSUE consumption cannot occur, because rnd_ready=0 while full.
- out_ready asserted when out_valid=0 is ignored.
- in_valid dropping before the handshake has no effect.

Decomposition:
- Shared package dom_pkg holds:
  - SHARES and RAND_BITS constants, plus a function computing RAND_BITS from SHARES
  - the FSM state typedef (2-bit enum IDLE/ISSUE/WAIT/DONE)
- Sub-module: dom_rand_buf, the one-entry randomness buffer with valid/ready and scrub-on-consume.
- The gadget itself stays outside. This block only drives and samples it.

Test Plan:
- Basic product, with a 1-cycle behavioural DOM gadget model on the bench:
  - Stimulus: rnd word 6'b101101 preloaded, then in_a=4'b0001, in_b=4'b0111.
  - Response: g_r=6'b101101 for exactly 1 cycle; out_valid 3 cycles after accept; XOR of out_c == 1; op_count=1.
- Randomness starvation:
  - Stimulus: operands accepted with rnd_valid=0 for 5 cycles.
  - Response: stays in ISSUE with g_a/g_b/g_r=0 and busy=1; after rnd_valid, issue occurs the next cycle and the result is correct.
- No reuse:
  - Stimulus: 3 back-to-back operations with rnd words 0x15, 0x2A, 0x3F.
  - Response: each g_r value appears exactly once, in order; rnd_ready=0 while buffered.
- Output backpressure:
  - Stimulus: out_ready=0 for 4 cycles in DONE.
  - Response: out_c stable, in_ready=0, out_valid held; count increments only on the handshake.
- Reset mid-op:
  - Stimulus: rst_n low during WAIT.
  - Response: all outputs 0 immediately (asynchronously), rnd_ready=1 after release; the next operation uses a new rnd word.
- Counter wrap:
  - Stimulus: op_count forced to 0xFFFF, then one operation completes.
  - Response: op_count=0x0000.
